// File: rtl/bus_master.sv
// Initiator side of the rq/ack/wr_ni memory-bus handshake with a timeout guard.
// Optional reissue-after-timeout is enabled by defining BUS_MASTER_RETRY_EN.
module bus_master #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_ni,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic                  rq,
    input  logic                  ack,
    output logic                  wr_ni,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] dataW,
    input  logic [DATA_WIDTH-1:0] dataR
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || MAX_RETRIES > 255) begin : g_bad_param
        $error("bus_master: TIMEOUT_CYCLES must be 2..255 and MAX_RETRIES at most 255");
    end

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGap
    } state_e;

    state_e                  state_q;
    logic [TimerW-1:0]       timer_q;
    logic                    rq_q;
    logic                    wr_ni_q;
    logic [ADDR_WIDTH-1:0]   address_q;
    logic [DATA_WIDTH-1:0]   data_w_q;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;

`ifdef BUS_MASTER_RETRY_EN
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    logic [RetryW-1:0] retry_cnt_q;
    // Set when GAP must loop back into REQ instead of IDLE.
    logic              retry_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            rq_q         <= 1'b0;
            wr_ni_q      <= 1'b1;
            address_q    <= '0;
            data_w_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
`ifdef BUS_MASTER_RETRY_EN
            retry_cnt_q  <= '0;
            retry_q      <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        wr_ni_q   <= cmd_wr_ni;
                        address_q <= cmd_addr;
                        data_w_q  <= cmd_data;
                        rq_q      <= 1'b1;
                        timer_q   <= '0;
`ifdef BUS_MASTER_RETRY_EN
                        retry_cnt_q <= '0;
`endif
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    // An ack on the expiry cycle still counts as success.
                    if (ack) begin
                        rq_q         <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        if (wr_ni_q) begin
                            resp_data_q <= dataR;
                        end
                        state_q      <= StGap;
                    end else if (timer_q == TimerLast) begin
                        rq_q    <= 1'b0;
                        state_q <= StGap;
`ifdef BUS_MASTER_RETRY_EN
                        if (retry_cnt_q < RetryMax) begin
                            retry_cnt_q <= retry_cnt_q + 1'b1;
                            retry_q     <= 1'b1;
                        end else
`endif
                        begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StGap: begin
`ifdef BUS_MASTER_RETRY_EN
                    if (retry_q) begin
                        retry_q <= 1'b0;
                        rq_q    <= 1'b1;
                        timer_q <= '0;
                        state_q <= StReq;
                    end else
`endif
                    begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign rq         = rq_q;
    assign wr_ni      = wr_ni_q;
    assign address    = address_q;
    assign dataW      = data_w_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed self-checking bench for bus_master against a small registered-ack RAM slave.
module tb_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_wr_ni;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       resp_valid, resp_err;
    logic [7:0] resp_data;
    logic       busy, rq, ack, wr_ni;
    logic [3:0] address;
    logic [7:0] dataW, dataR;

    // Slave mode: 0 = RAM (ack = rq && rq_d), 1 = ack tied low, 2 = ack from ack_force.
    int         mode = 0;
    logic       ack_force = 1'b0;
    logic       rq_d;
    logic [7:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_master #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(16),
        .MAX_RETRIES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr_ni(cmd_wr_ni),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .resp_valid(resp_valid),
        .resp_err(resp_err),
        .resp_data(resp_data),
        .busy(busy),
        .rq(rq),
        .ack(ack),
        .wr_ni(wr_ni),
        .address(address),
        .dataW(dataW),
        .dataR(dataR)
    );

    assign ack   = (mode == 0) ? (rq && rq_d) : ((mode == 2) ? ack_force : 1'b0);
    assign dataR = mem[address];

    always @(posedge clk) begin
        if (rst) begin
            rq_d <= 1'b0;
            for (int k = 0; k < 16; k++) mem[k] <= 8'h00;
        end else begin
            rq_d <= rq;
            if (ack && rq && !wr_ni) mem[address] <= dataW;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the last run_txn; indices count negedges after the accept edge.
    int         rq_cnt, resp_cnt, resp_idx, ready_idx, unstable;
    logic       r_err;
    logic [7:0] r_data;
    logic       done;

    task automatic run_txn(input logic wr, input logic [3:0] a, input logic [7:0] d,
                           input int ack_at);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr_ni = wr;
        cmd_addr  = a;
        cmd_data  = d;
        @(posedge clk);
        rq_cnt = 0; resp_cnt = 0; resp_idx = -1; ready_idx = -1; unstable = 0;
        r_err = 1'b0; r_data = 8'h00; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rq) begin
                rq_cnt++;
                if (address != a || wr_ni != wr || dataW != d) unstable++;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (resp_idx < 0) resp_idx = i;
                r_err  = resp_err;
                r_data = resp_data;
            end
            if (cmd_ready && ready_idx < 0) ready_idx = i;
            if (ready_idx >= 0 && i >= ready_idx + 2) done = 1'b1;
            ack_force = (i == ack_at);
        end
        ack_force = 1'b0;
        check("txn_budget", 32'(done), 32'd1);
    endtask

    logic rq_hist [16];
    int   nresp2, low_run, first_fall;
    logic [7:0] last_data;
    logic acc2, acc2_pend;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr_ni = 1'b1; cmd_addr = '0; cmd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rq", 32'(rq), 32'd0);
        check("rst_wr_ni", 32'(wr_ni), 32'd1);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_dataW", 32'(dataW), 32'd0);
        check("rst_resp", {resp_valid, resp_err, 8'h00, resp_data}, 32'd0);
        check("rst_busy_ready", {busy, cmd_ready}, 32'b01);
        rst = 1'b0;

        // Write 3 <- A5.
        mode = 0;
        run_txn(1'b0, 4'h3, 8'hA5, -1);
        check("wr_rq_cycles", rq_cnt, 2);
        check("wr_bus_stable", unstable, 0);
        check("wr_resp_cnt", resp_cnt, 1);
        check("wr_resp_idx", resp_idx, 2);
        check("wr_resp_err", 32'(r_err), 32'd0);
        check("wr_resp_data_kept", 32'(r_data), 32'h00);
        check("wr_mem3", 32'(mem[3]), 32'hA5);

        // Read back address 3.
        run_txn(1'b1, 4'h3, 8'h00, -1);
        check("rd_resp_idx", resp_idx, 2);
        check("rd_ready_idx", ready_idx, 3);
        check("rd_data", 32'(r_data), 32'hA5);
        check("rd_err", 32'(r_err), 32'd0);
        check("rd_bus_stable", unstable, 0);

        // Back-to-back: write 5 <- 3C then read 5, source holding cmd_valid.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr_ni = 1'b0; cmd_addr = 4'h5; cmd_data = 8'h3C;
        @(posedge clk);
        nresp2 = 0; last_data = 8'h00; acc2 = 1'b0; acc2_pend = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rq_hist[i] = rq;
            if (resp_valid) begin
                nresp2++;
                last_data = resp_data;
            end
            if (i == 0) begin
                cmd_wr_ni = 1'b1; cmd_data = 8'h00;
            end
            if (acc2_pend) begin
                cmd_valid = 1'b0;
                acc2_pend = 1'b0;
            end
            if (cmd_ready && cmd_valid && !acc2) begin
                acc2 = 1'b1;
                acc2_pend = 1'b1;
            end
        end
        first_fall = -1; low_run = 0;
        for (int i = 0; i < 12; i++) begin
            if (first_fall < 0 && !rq_hist[i]) first_fall = i;
        end
        for (int i = 0; i < 12; i++) begin
            if (first_fall >= 0 && i >= first_fall && !rq_hist[i] && low_run == i - first_fall)
                low_run++;
        end
        // Low gap between bursts = the GAP cycle plus the IDLE cycle that accepts.
        check("b2b_rq_low_gap", low_run, 2);
        check("b2b_resp_cnt", nresp2, 2);
        check("b2b_rd_data", 32'(last_data), 32'h3C);
        check("b2b_mem5", 32'(mem[5]), 32'h3C);

        // Ack tied low: timeout.
        mode = 1;
        run_txn(1'b1, 4'h7, 8'h00, -1);
`ifdef BUS_MASTER_RETRY_EN
        check("to_rq_cycles", rq_cnt, 32);
        check("to_resp_idx", resp_idx, 33);
`else
        check("to_rq_cycles", rq_cnt, 16);
        check("to_resp_idx", resp_idx, 16);
`endif
        check("to_resp_cnt", resp_cnt, 1);
        check("to_err", 32'(r_err), 32'd1);
        check("to_data", 32'(r_data), 32'h00);

        // Ack arrives on the expiry cycle: success wins.
        mode = 2;
        run_txn(1'b1, 4'h3, 8'h00, 15);
        check("late_ack_rq_cycles", rq_cnt, 16);
        check("late_ack_err", 32'(r_err), 32'd0);
        check("late_ack_data", 32'(r_data), 32'hA5);
        check("late_ack_resp_idx", resp_idx, 16);

        // Ack in IDLE is ignored.
        @(negedge clk);
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ack_ignored", {busy, resp_valid, rq}, 32'd0);
        ack_force = 1'b0;

        // Reset during the second REQ cycle.
        mode = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr_ni = 1'b0; cmd_addr = 4'h9; cmd_data = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_mid_rq_before", 32'(rq), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rq", 32'(rq), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_resp_after", {resp_valid, rq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
